decode: RTL and testbench
=========================

Name: decode

Overview:
- Instruction-decode (ID) stage of the 5-stage RV32 pipeline; sits between the IF/ID and ID/EX registers.
- Decodes the instruction and generates control signals and the immediate.
- Holds the 32x32 register file, written back from WB.
- Resolves BEQ in ID and produces the branch target and IF mux select.
- Detects data hazards and stalls PC and IF/ID.
- Decoded fields and controls leave through an internal ID/EX pipeline register.

Parameters:
- None. Widths fixed: XLEN 32, 32 registers, 5-bit register indices.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- write_enable  in  1  register-file write strobe from WB.
- instruction  in  32  instruction from IF/ID.
- pc  in  32  PC of the instruction.
- Din  in  32  write-back data.
- dest_ex_mem  in  5  destination register of the instruction in MEM.
- dest_mem_wb  in  5  destination register of the instruction in WB; also the register-file write address.
- reg_destino_exe  in  5  destination register of the instruction in EX.
- pc_enable  out  1  PC update enable (combinational).
- if_id_enable  out  1  IF/ID register enable (combinational).
- mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out, aluSrc_out  out  1 each  registered controls.
- aluOp_out  out  2  registered ALU op class.
- rs1_out, rs2_out, rd_out  out  5 each  registered fields: instruction[19:15], [24:20], [11:7].
- imediato_out  out  32  registered sign-extended immediate.
- pc_branch_value  out  32  branch target (combinational).
- mux_sel_IF  out  1  1 = IF selects pc_branch_value (combinational).

Behaviour:
- Decode by opcode instruction[6:0]. Control fields are {reg_write, mem_read, mem_to_reg, mem_write, beq, aluSrc, aluOp}:
  - 0110011 R-type: {1,0,0,0,0,0,10}. Sources used: rs1, rs2. Immediate 0.
  - 0000011 load: {1,1,1,0,0,1,00}. Source used: rs1. Immediate = sext(inst[31:20]).
  - 0100011 store: {0,0,0,1,0,1,00}. Sources used: rs1, rs2. Immediate = sext({inst[31:25], inst[11:7]}).
  - 1100011 beq: {0,0,0,0,1,0,01}. Sources used: rs1, rs2. Immediate = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - Any other opcode: all controls 0, no sources used, immediate 0.
- pc_branch_value = pc + immediate, combinational, 32-bit wrap-around. Equals pc for R-type.
- Register file:
  - x0 always reads 0.
  - Write on rising clock when write_enable=1 and dest_mem_wb != 0; Din goes to R[dest_mem_wb].
  - Reads are combinational with write-through: if write_enable=1, dest_mem_wb != 0 and the address matches, the read returns Din.
  - On reset all registers clear to 0.
- Hazard (stall), combinational: stall=1 when a used source register is nonzero and equals reg_destino_exe or dest_ex_mem.
  - A match against dest_mem_wb alone never stalls; write-through covers it.
- pc_enable = if_id_enable = ~stall.
- mux_sel_IF = beq & ~stall & (R[rs1] == R[rs2]).
- ID/EX register, updated on rising clock:
  - On reset or stall, all registered outputs load 0 (bubble).
  - Otherwise they load the decoded controls, rs1, rs2, rd and immediate.
  - Latency is 1 cycle from instruction to the _out signals.
- Reset values:
  - All registered outputs 0.
  - The combinational outputs follow the inputs while reset is held; the register file is already cleared.
- Simultaneous write-back and branch compare on the same register uses Din (write-through).

Test Plan:
- Reset, then R-type add (0x00638 2B3 pattern: rs1=7, rs2=6, rd=5), pc=0x10, hazard inputs 0.
  - Combinational: pc_branch_value=0x10, pc_enable=1, if_id_enable=1.
  - After 1 clock: rs1_out=7, rs2_out=6, rd_out=5, reg_write_out=1, aluOp_out=10.
- beq x1,x2 with inst[11:7]=00100, pc=0x20, registers 0 after reset.
  - Immediate 4, pc_branch_value=0x24, mux_sel_IF=1.
  - After 1 clock: beq_instruction_out=1.
- R-type with rs1=2, rs2=1, dest_ex_mem=1.
  - pc_enable=0, if_id_enable=0, mux_sel_IF=0.
  - After 1 clock: all registered outputs 0.
- lw with inst[31:20]=3, rs1=3, rd=4, pc=0x30, dest_ex_mem=1.
  - No stall.
  - After 1 clock: rs1_out=3, rd_out=4, imediato_out=0x00000003, mem_read_out=1, mem_to_reg_out=1, aluSrc_out=1.
- Store with rs1=1, rs2=2, dest_mem_wb=2, dest_ex_mem=1.
  - Stall (rs1 matches EX/MEM): pc_enable=0.
  - Then set dest_ex_mem=0 with dest_mem_wb=2: no stall, pc_enable=1.
- write_enable=1, dest_mem_wb=1, Din=5, then beq x1,x2.
  - Before the clock edge, write-through gives unequal operands: mux_sel_IF=0.
  - Write with dest_mem_wb=0: x0 remains 0.

Source files
------------

// File: rtl/decode.sv
// Instruction-decode stage: control/immediate decode, register file, BEQ resolution,
// load-use style hazard stall and the ID/EX pipeline register.
module decode (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [31:0] Din,
  input  logic [4:0]  dest_ex_mem,
  input  logic [4:0]  dest_mem_wb,
  input  logic [4:0]  reg_destino_exe,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        beq_instruction_out,
  output logic        aluSrc_out,
  output logic [1:0]  aluOp_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [31:0] imediato_out,
  output logic [31:0] pc_branch_value,
  output logic        mux_sel_IF
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        unused_funct3;

  assign opcode        = instruction[6:0];
  assign rs1           = instruction[19:15];
  assign rs2           = instruction[24:20];
  assign rd            = instruction[11:7];
  assign unused_funct3 = ^instruction[14:12];

  logic        reg_write_d, mem_read_d, mem_to_reg_d, mem_write_d, beq_d, alu_src_d;
  logic [1:0]  alu_op_d;
  logic [31:0] imm_d;
  logic        use_rs1, use_rs2;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    beq_d        = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = 2'b00;
    imm_d        = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        alu_op_d    = 2'b10;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
        imm_d        = {{20{instruction[31]}}, instruction[31:20]};
        use_rs1      = 1'b1;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_BEQ: begin
        beq_d    = 1'b1;
        alu_op_d = 2'b01;
        imm_d    = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; x0 is never written and always reads zero.
  logic [31:0] regs_q [32];
  logic        wb_hit;
  logic [31:0] rs1_val, rs2_val;

  assign wb_hit = write_enable && (dest_mem_wb != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[dest_mem_wb] <= Din;
    end
  end

  always_comb begin
    if (rs1 == 5'd0)                         rs1_val = '0;
    else if (wb_hit && dest_mem_wb == rs1)   rs1_val = Din;
    else                                     rs1_val = regs_q[rs1];
    if (rs2 == 5'd0)                         rs2_val = '0;
    else if (wb_hit && dest_mem_wb == rs2)   rs2_val = Din;
    else                                     rs2_val = regs_q[rs2];
  end

  // A match against WB alone is resolved by write-through, so only EX and MEM stall.
  logic stall;
  assign stall = (use_rs1 && rs1 != 5'd0 && (rs1 == reg_destino_exe || rs1 == dest_ex_mem)) ||
                 (use_rs2 && rs2 != 5'd0 && (rs2 == reg_destino_exe || rs2 == dest_ex_mem));

  assign pc_enable       = ~stall;
  assign if_id_enable    = ~stall;
  assign pc_branch_value = pc + imm_d;
  assign mux_sel_IF      = beq_d & ~stall & (rs1_val == rs2_val);

  logic        reg_write_q, mem_read_q, mem_to_reg_q, mem_write_q, beq_q, alu_src_q;
  logic [1:0]  alu_op_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] imm_q;

  always_ff @(posedge clock) begin
    if (reset || stall) begin
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      beq_q        <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 2'b00;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      beq_q        <= beq_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      rd_q         <= rd;
      imm_q        <= imm_d;
    end
  end

  assign reg_write_out       = reg_write_q;
  assign mem_read_out        = mem_read_q;
  assign mem_to_reg_out      = mem_to_reg_q;
  assign mem_write_out       = mem_write_q;
  assign beq_instruction_out = beq_q;
  assign aluSrc_out          = alu_src_q;
  assign aluOp_out           = alu_op_q;
  assign rs1_out             = rs1_q;
  assign rs2_out             = rs2_q;
  assign rd_out              = rd_q;
  assign imediato_out        = imm_q;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a driver pushes expected combinational and ID/EX values,
// a monitor pops and compares them as the DUT presents each.
module tb_decode;

  logic        clock = 1'b0;
  logic        reset, write_enable;
  logic [31:0] instruction, pc, Din;
  logic [4:0]  dest_ex_mem, dest_mem_wb, reg_destino_exe;
  logic        pc_enable, if_id_enable, mem_to_reg_out, reg_write_out, mem_read_out;
  logic        mem_write_out, beq_instruction_out, aluSrc_out, mux_sel_IF;
  logic [1:0]  aluOp_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [31:0] imediato_out, pc_branch_value;

  always #5 clock = ~clock;

  decode dut (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .instruction(instruction), .pc(pc), .Din(Din),
    .dest_ex_mem(dest_ex_mem), .dest_mem_wb(dest_mem_wb), .reg_destino_exe(reg_destino_exe),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .beq_instruction_out(beq_instruction_out), .aluSrc_out(aluSrc_out),
    .aluOp_out(aluOp_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .imediato_out(imediato_out), .pc_branch_value(pc_branch_value), .mux_sel_IF(mux_sel_IF)
  );

  typedef struct {
    logic        check;
    logic [34:0] val;   // {branch target, pc_enable, if_id_enable, mux_sel_IF}
  } comb_exp_t;

  comb_exp_t   comb_q[$];
  logic [54:0] idex_q[$]; // {rw, mr, m2r, mw, beq, src, aluop, rs1, rs2, rd, imm}

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [32];

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return model_regs[a];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [31:0] inst,
                       input logic [31:0] pcv, input logic [31:0] din,
                       input logic [4:0] dexm, input logic [4:0] dmwb, input logic [4:0] dexe);
    logic [6:0]  op;
    logic [4:0]  s1, s2;
    logic        u1, u2, stall, eq;
    logic [5:0]  ctl;
    logic [1:0]  aop;
    logic [31:0] imm;
    logic signed [12:0] bimm;
    logic signed [11:0] simm;
    comb_exp_t ce;
    @(posedge clock);
    #2;
    reset = rst; write_enable = we; instruction = inst; pc = pcv; Din = din;
    dest_ex_mem = dexm; dest_mem_wb = dmwb; reg_destino_exe = dexe;

    op = inst[6:0]; s1 = inst[19:15]; s2 = inst[24:20];
    ctl = 6'b0; aop = 2'b00; imm = 32'd0; u1 = 0; u2 = 0;
    if (op == 7'b0110011) begin
      ctl = 6'b100000; aop = 2'b10; u1 = 1; u2 = 1;
    end else if (op == 7'b0000011) begin
      ctl = 6'b111001; u1 = 1;
      simm = inst[31:20]; imm = 32'(simm);
    end else if (op == 7'b0100011) begin
      ctl = 6'b000101; u1 = 1; u2 = 1;
      simm = {inst[31:25], inst[11:7]}; imm = 32'(simm);
    end else if (op == 7'b1100011) begin
      ctl = 6'b000010; aop = 2'b01; u1 = 1; u2 = 1;
      bimm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; imm = 32'(bimm);
    end
    stall = (u1 && s1 != 0 && (s1 == dexe || s1 == dexm)) ||
            (u2 && s2 != 0 && (s2 == dexe || s2 == dexm));
    eq = model_read(s1, we && dmwb != 0, dmwb, din) == model_read(s2, we && dmwb != 0, dmwb, din);

    ce.check = !rst;
    ce.val   = {pcv + imm, !stall, !stall, ctl[1] && !stall && eq};
    comb_q.push_back(ce);
    if (rst || stall) idex_q.push_back(55'd0);
    else idex_q.push_back({ctl[5], ctl[4], ctl[3], ctl[2], ctl[1], ctl[0], aop,
                           s1, s2, inst[11:7], imm});

    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (we && dmwb != 0) begin
      model_regs[dmwb] = din;
    end
  endtask

  initial begin : monitor
    comb_exp_t   ce;
    logic [54:0] ie;
    logic [34:0] ca;
    logic [54:0] ia;
    forever begin
      @(negedge clock);
      if (comb_q.size() > 0) begin
        ce = comb_q.pop_front();
        ca = {pc_branch_value, pc_enable, if_id_enable, mux_sel_IF};
        if (ce.check) begin
          checks++;
          if (ca !== ce.val) begin
            errors++;
            $display("FAIL comb: got %h expected %h (inst %h)", ca, ce.val, instruction);
          end
        end
      end
      @(posedge clock);
      #1;
      if (idex_q.size() > 0) begin
        ie = idex_q.pop_front();
        ia = {reg_write_out, mem_read_out, mem_to_reg_out, mem_write_out,
              beq_instruction_out, aluSrc_out, aluOp_out, rs1_out, rs2_out, rd_out, imediato_out};
        checks++;
        if (ia !== ie) begin
          errors++;
          $display("FAIL idex: got %h expected %h", ia, ie);
        end
      end
    end
  end

  initial begin : stimulus
    logic [6:0]  ops [5];
    logic [31:0] inst, dv;
    int          wait_cycles;
    ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
    ops[3] = 7'b1100011; ops[4] = 7'b0010011;
    reset = 1; write_enable = 0; instruction = 0; pc = 0; Din = 0;
    dest_ex_mem = 0; dest_mem_wb = 0; reg_destino_exe = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    drive(1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 32'h006382B3, 32'h10, 32'h0, 5'd0, 5'd0, 5'd0);  // add x5,x7,x6
    drive(0, 0, 32'h00208263, 32'h20, 32'h0, 5'd0, 5'd0, 5'd0);  // beq x1,x2,+4
    drive(0, 0, 32'h001101B3, 32'h0,  32'h0, 5'd1, 5'd0, 5'd0);  // rs2 hits MEM
    drive(0, 0, 32'h0031A203, 32'h30, 32'h0, 5'd1, 5'd0, 5'd0);  // lw x4,3(x3)
    drive(0, 0, 32'h0020A023, 32'h40, 32'h0, 5'd1, 5'd2, 5'd0);  // sw stall on rs1
    drive(0, 0, 32'h0020A023, 32'h40, 32'h0, 5'd0, 5'd2, 5'd0);  // WB match only
    drive(0, 1, 32'h00208263, 32'h50, 32'd5, 5'd0, 5'd1, 5'd0);  // write-through x1=5
    drive(0, 1, 32'h00200263, 32'h60, 32'd7, 5'd0, 5'd0, 5'd0);  // write to x0 ignored
    drive(0, 0, 32'h00200263, 32'h60, 32'h0, 5'd0, 5'd0, 5'd0);  // beq x0,x2 taken
    drive(0, 0, 32'hFE208EE3, 32'h70, 32'h0, 5'd0, 5'd0, 5'd0);  // negative branch offset
    drive(0, 0, 32'hFFF0A203, 32'h80, 32'h0, 5'd0, 5'd0, 5'd0);  // lw with imm -1

    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 4)];
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: dv = 32'd0;
        1: dv = 32'd5;
        default: dv = $urandom;
      endcase
      drive($urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)), inst, $urandom, dv,
            5'($urandom_range(0, 9)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 9)));
    end

    wait_cycles = 0;
    while ((comb_q.size() > 0 || idex_q.size() > 0) && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    @(posedge clock);
    #3;
    if (comb_q.size() > 0 || idex_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d comb and %0d idex entries left, expected 0",
               comb_q.size(), idex_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
